// File: rtl/conv1x1_ifm_aligner_if.sv
// rtl/conv1x1_ifm_aligner_if.sv - IFM beat in / aligned PE beat out handshake bundle
interface conv1x1_ifm_aligner_if #(
    parameter int DW        = 16,
    parameter int LANES_IN  = 16,
    parameter int LANES_OUT = 13
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES_IN*DW-1:0]    in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES_OUT*DW-1:0]   out_data;
    logic                      out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv1x1_ifm_aligner.sv
// rtl/conv1x1_ifm_aligner.sv - 1x1-conv IFM lane aligner with 2-entry output FIFO
// Optional lane zero-padding on row-final tiles: define CONV1X1_ZERO_PAD_EN.
module conv1x1_ifm_aligner #(
    parameter int DW        = 16,
    parameter int LANES_IN  = 16,
    parameter int LANES_OUT = 13,
    parameter int WW        = 9
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cfg_start_i,
    input  logic          cfg_enable_i,
    input  logic [WW-1:0] cfg_width_i,
    conv1x1_ifm_aligner_if.slave bus
);
    localparam int SHIFT_MAX = LANES_IN - LANES_OUT;
    localparam int RW        = (SHIFT_MAX > 0) ? $clog2(SHIFT_MAX + 1) : 1;
    localparam int OW        = LANES_OUT * DW;

    logic          en_q;
    logic [WW-1:0] tpr_q;
    logic [WW-1:0] tile_cnt_q;
    logic [WW-1:0] row_cnt_q;
    logic [WW-1:0] tpr_d;

    // FIFO entries carry {last, data}; head_q drives the output pins directly
    logic [OW:0]   head_q, head_d;
    logic [OW:0]   skid_q, skid_d;
    logic [1:0]    count_q, count_d;
    logic          out_valid_q;

    logic          push;
    logic          pop;
    logic          last_now;
    logic [WW-1:0] sel_cnt;
    logic [RW-1:0] remain;
    logic [RW-1:0] offset;
    logic [OW-1:0] sel_data;
    logic [OW:0]   new_entry;

    assign tpr_d = WW'(({1'b0, cfg_width_i} + (WW+1)'(LANES_OUT - 1)) / (WW+1)'(LANES_OUT));

    assign bus.in_ready  = !rst_i && (count_q != 2'd2) && !cfg_start_i;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = head_q[OW-1:0];
    assign bus.out_last  = head_q[OW];

    assign push = bus.in_valid && bus.in_ready && en_q;
    assign pop  = out_valid_q && bus.out_ready;

    // Single-tile rows rotate the shift per row instead of per tile
    assign last_now = (tile_cnt_q == tpr_q - WW'(1));
    assign sel_cnt  = (tpr_q == WW'(1)) ? row_cnt_q : tile_cnt_q;
    assign remain   = RW'(sel_cnt % WW'(SHIFT_MAX + 1));
    assign offset   = RW'(SHIFT_MAX) - remain;
    assign sel_data = OW'(bus.in_data >> (32'(offset) * 32'(DW)));

`ifdef CONV1X1_ZERO_PAD_EN
    logic [WW-1:0] width_q;
    logic [OW-1:0] pad_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            width_q <= '0;
        end else if (cfg_start_i) begin
            width_q <= cfg_width_i;
        end
    end

    // Lanes past the row end on the final tile carry no pixels
    always_comb begin
        pad_data = sel_data;
        if (last_now) begin
            for (int j = 0; j < LANES_OUT; j++) begin
                if ((32'(tile_cnt_q) * 32'(LANES_OUT) + 32'(j)) >= 32'(width_q)) begin
                    pad_data[j*DW +: DW] = '0;
                end
            end
        end
    end

    assign new_entry = {last_now, pad_data};
`else
    assign new_entry = {last_now, sel_data};
`endif

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case ({push, pop})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) begin
                    head_d = new_entry;
                end else begin
                    skid_d = new_entry;
                end
            end
            2'b01: begin
                count_d = count_q - 2'd1;
                if (count_q == 2'd2) begin
                    head_d = skid_q;
                end
            end
            2'b11: begin
                // push needs count<2 and pop needs count>0, so the head simply turns over
                head_d = new_entry;
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q        <= 1'b0;
            tpr_q       <= '0;
            tile_cnt_q  <= '0;
            row_cnt_q   <= '0;
            count_q     <= 2'd0;
            head_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (cfg_start_i) begin
            en_q        <= cfg_enable_i;
            tpr_q       <= tpr_d;
            tile_cnt_q  <= '0;
            row_cnt_q   <= '0;
            count_q     <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            if (push) begin
                if (last_now) begin
                    tile_cnt_q <= '0;
                    row_cnt_q  <= row_cnt_q + WW'(1);
                end else begin
                    tile_cnt_q <= tile_cnt_q + WW'(1);
                end
            end
            count_q     <= count_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            out_valid_q <= (count_d != 2'd0);
        end
    end
endmodule
